alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 16x16 multiplier sequencer that owns the 16-bit ALU's control word and operand inputs.
- Builds the low 16 bits of the product by shift-and-add: every addition and every doubling is issued to the ALU as an a+b operation (control 000010), and the ALU output is captured back into internal registers.
- Sits between the CPU-side request/response handshake and the shared ALU. Provides multiply without adding a second adder.

Parameters:
- ADD_CTRL, 6'b000010, ALU control word for a+b (order zx,nx,zy,ny,f,no).
- ZERO_CTRL, 6'b101010, ALU control word for constant 0, driven whenever the ALU is not in use.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE (combinational from state).
- op_a  in  16  multiplicand, sampled on accept.
- op_b  in  16  multiplier, sampled on accept.
- out_valid  out  1  high only in DONE.
- out_ready  in  1  response consumer ready.
- result  out  16  low 16 bits of op_a*op_b.
- overflow  out  1  set when the true product is at least 2^16.
- alu_c  out  6  ALU control word.
- alu_a  out  16  ALU operand a.
- alu_b  out  16  ALU operand b.
- alu_out  in  16  ALU result; the ALU is combinational, so the result is valid in the same cycle.

Behaviour:
- Internal registers: state, acc[15:0], mcand[15:0], mplier[15:0], lost (sticky), ovf (sticky).
- Outputs: result = acc, overflow = ovf.
- Reset (synchronous): state=IDLE; acc, mcand, mplier = 0; lost, ovf = 0.
  - Therefore result=0, overflow=0, out_valid=0, in_ready=1, alu_c=ZERO_CTRL, alu_a=alu_b=0.
  - Reset asserted in any state, including mid-operation, aborts the operation; no response is produced.
- ALU drive:
  - ADD state: alu_c=ADD_CTRL, alu_a=acc, alu_b=mcand.
  - DBL state: alu_c=ADD_CTRL, alu_a=alu_b=mcand.
  - All other states: alu_c=ZERO_CTRL, alu_a=alu_b=0.
- IDLE:
  - Accept when in_valid && in_ready. On accept: acc<=0, mcand<=op_a, mplier<=op_b, lost<=0, ovf<=0.
  - Next state: op_b==0 -> DONE; op_b[0]==1 -> ADD; else DBL.
  - Without accept: hold. result/overflow keep the last product.
- ADD:
  - acc<=alu_out.
  - ovf<=ovf | lost | (alu_out < acc, unsigned compare = wrap).
  - Next: mplier[15:1]==0 -> DONE, else DBL.
- DBL:
  - mcand<=alu_out; lost<=lost | mcand[15]; mplier<=mplier>>1.
  - Next: new mplier[0]==1 -> ADD, else DBL.
  - DBL is entered only when mplier[15:1]!=0, so the loop always terminates.
- DONE:
  - out_valid=1. result/overflow held stable.
  - When out_ready: go to IDLE; else hold.
  - in_valid is ignored outside IDLE (no overlap of requests).
- Latency: busy cycles (ADD+DBL) = popcount(op_b) + index of MSB of op_b.
  - op_b==0 gives 0 busy cycles; 0xFFFF gives the maximum, 31.
  - out_valid rises the cycle after the last busy cycle.
  - Accept to out_valid = busy+1 cycles.
- Overflow is exact for unsigned operands:
  - A discarded mcand bit that is later added implies product >= 2^16.
  - Any wrapping add also implies product >= 2^16.
  - Discarded bits that are never added do not set overflow.
- The ALU zr/ng flags are not used; all decisions come from local compares.

Test Plan:
- Reset held 2 cycles, then released -> in_ready=1, out_valid=0, result=0, overflow=0, alu_c=101010.
- op_a=3, op_b=5 accepted -> states ADD,DBL,DBL,ADD (alu_c=000010 for 4 cycles; alu_a/alu_b=0/3, 3/3, 6/6, 3/12) -> out_valid with result=15, overflow=0.
- op_a=1234, op_b=0 -> DONE on the next cycle, 0 ALU cycles, result=0, overflow=0.
- op_a=0xFFFF, op_b=0xFFFF -> 31 busy cycles, result=0x0001, overflow=1.
- Overflow boundaries:
  - 256*256 -> result=0x0000, overflow=1 (lost bit).
  - 255*257 -> result=0xFFFF, overflow=0.
  - 0x8000*1 -> result=0x8000, overflow=0.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
  - Separately, assert reset during DBL -> IDLE, result=0, out_valid never asserted.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Multi-cycle unsigned 16x16 multiplier that borrows a shared 16-bit ALU.
//   The low 16 bits of the product are built by shift-and-add, where every
//   addition (acc + mcand) and every doubling (mcand + mcand) is issued to the
//   ALU as an a+b operation and the ALU result is captured back locally.
//   Overflow is tracked exactly for unsigned operands.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any operation, returns to IDLE
//   in_valid   request valid (ignored outside IDLE)
//   in_ready   high only in IDLE
//   op_a       multiplicand, sampled on accept
//   op_b       multiplier, sampled on accept
//   out_valid  high only in DONE
//   out_ready  response consumer ready
//   result     low 16 bits of op_a*op_b
//   overflow   true product >= 2^16
//   alu_c      ALU control word (zx,nx,zy,ny,f,no)
//   alu_a      ALU operand a
//   alu_b      ALU operand b
//   alu_out    combinational ALU result for the current alu_c/alu_a/alu_b
module alu_mul_seq #(
  parameter logic [5:0] ADD_CTRL  = 6'b000010,
  parameter logic [5:0] ZERO_CTRL = 6'b101010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic [5:0]  alu_c,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DBL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        lost;
  logic        ovf;
  logic [15:0] mplier_shr;

  assign mplier_shr = mplier >> 1;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = acc;
  assign overflow  = ovf;

  // The ALU is only driven with real operands while adding or doubling;
  // otherwise it is parked on constant zero so it sees quiet inputs.
  always_comb begin
    alu_c = ZERO_CTRL;
    alu_a = 16'd0;
    alu_b = 16'd0;
    case (state)
      S_ADD: begin
        alu_c = ADD_CTRL;
        alu_a = acc;
        alu_b = mcand;
      end
      S_DBL: begin
        alu_c = ADD_CTRL;
        alu_a = mcand;
        alu_b = mcand;
      end
      default: ;
    endcase
  end

  // Sequencer. An add wraps exactly when the sum is below the old accumulator.
  // A multiplicand bit pushed out by a doubling only matters if a later add
  // uses that multiplicand, so 'lost' is folded into 'ovf' only at add time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= 16'd0;
      mcand  <= 16'd0;
      mplier <= 16'd0;
      lost   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc    <= 16'd0;
            mcand  <= op_a;
            mplier <= op_b;
            lost   <= 1'b0;
            ovf    <= 1'b0;
            if (op_b == 16'd0)
              state <= S_DONE;
            else if (op_b[0])
              state <= S_ADD;
            else
              state <= S_DBL;
          end
        end
        S_ADD: begin
          acc <= alu_out;
          ovf <= ovf | lost | (alu_out < acc);
          if (mplier[15:1] == 15'd0)
            state <= S_DONE;
          else
            state <= S_DBL;
        end
        S_DBL: begin
          mcand  <= alu_out;
          lost   <= lost | mcand[15];
          mplier <= mplier_shr;
          if (mplier_shr[0])
            state <= S_ADD;
          else
            state <= S_DBL;
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
//   Directed bench for alu_mul_seq. A behavioural model of the shared ALU
//   answers the sequencer combinationally; every expected value below is a
//   hand-computed constant.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic [5:0]  alu_c;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;

  int n_checks;
  int n_pass;

  alu_mul_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .alu_c     (alu_c),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack-style ALU: zx,nx,zy,ny,f,no.
  always_comb begin
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] o;
    x = alu_c[5] ? 16'd0 : alu_a;
    x = alu_c[4] ? ~x : x;
    y = alu_c[3] ? 16'd0 : alu_b;
    y = alu_c[2] ? ~y : y;
    o = alu_c[1] ? (x + y) : (x & y);
    alu_out = alu_c[0] ? ~o : o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drive request inputs just after a falling edge.
  task automatic applyStimulus(input logic v, input logic [15:0] a,
                               input logic [15:0] b, input logic rdy);
    in_valid  = v;
    op_a      = a;
    op_b      = b;
    out_ready = rdy;
  endtask

  // Accept a request, count busy cycles until out_valid, check the response,
  // then optionally release it back to IDLE.
  task automatic runMul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic exp_ovf,
                        input int exp_busy, input logic release_it);
    int busy;
    checkOutput({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, a, b, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
    busy = 0;
    while (!out_valid && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    checkOutput({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, " busy"}, busy, exp_busy);
    checkOutput({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
    checkOutput({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    if (release_it) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, " back idle"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic saw_valid;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst result", {16'd0, result}, 32'd0);
    checkOutput("rst overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst alu_c", {26'd0, alu_c}, 32'h2A);
    checkOutput("rst alu_ab", {alu_a, alu_b}, 32'd0);

    // 3*5 with the ALU traffic checked cycle by cycle: ADD,DBL,DBL,ADD.
    $display("[TB] 3 x 5");
    applyStimulus(1'b1, 16'd3, 16'd5, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
    checkOutput("3x5 c0", {26'd0, alu_c}, 32'h02);
    checkOutput("3x5 ab0", {alu_a, alu_b}, {16'd0, 16'd3});
    @(negedge clk);
    checkOutput("3x5 c1", {26'd0, alu_c}, 32'h02);
    checkOutput("3x5 ab1", {alu_a, alu_b}, {16'd3, 16'd3});
    @(negedge clk);
    checkOutput("3x5 c2", {26'd0, alu_c}, 32'h02);
    checkOutput("3x5 ab2", {alu_a, alu_b}, {16'd6, 16'd6});
    @(negedge clk);
    checkOutput("3x5 c3", {26'd0, alu_c}, 32'h02);
    checkOutput("3x5 ab3", {alu_a, alu_b}, {16'd3, 16'd12});
    @(negedge clk);
    checkOutput("3x5 out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("3x5 result", {16'd0, result}, 32'd15);
    checkOutput("3x5 overflow", {31'd0, overflow}, 32'd0);
    checkOutput("3x5 done alu_c", {26'd0, alu_c}, 32'h2A);

    // Backpressure: response held, new request ignored.
    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'd7, 16'd7, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("bp result %0d", i), {16'd0, result}, 32'd15);
      checkOutput($sformatf("bp in_ready %0d", i), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("bp out_valid %0d", i), {31'd0, out_valid}, 32'd1);
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
    checkOutput("bp idle in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("idle hold result", {16'd0, result}, 32'd15);
    checkOutput("idle alu_c", {26'd0, alu_c}, 32'h2A);

    $display("[TB] directed products");
    runMul("1234x0", 16'd1234, 16'd0, 16'd0, 1'b0, 0, 1'b1);
    runMul("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 31, 1'b1);
    runMul("256x256", 16'd256, 16'd256, 16'h0000, 1'b1, 9, 1'b1);
    runMul("255x257", 16'd255, 16'd257, 16'hFFFF, 1'b0, 10, 1'b1);
    runMul("8000x1", 16'h8000, 16'd1, 16'h8000, 1'b0, 1, 1'b1);
    runMul("100x200", 16'd100, 16'd200, 16'd20000, 1'b0, 10, 1'b1);

    // Abort: reset while doubling; no response may appear.
    $display("[TB] abort in DBL");
    applyStimulus(1'b1, 16'd9, 16'd4, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    checkOutput("abort in DBL", {26'd0, alu_c, alu_a[7:0], alu_b[7:0]},
                {26'd2, 8'd9, 8'd9});
    reset = 1'b1;
    saw_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    checkOutput("abort no valid", {31'd0, saw_valid}, 32'd0);
    checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort result", {16'd0, result}, 32'd0);
    checkOutput("abort overflow", {31'd0, overflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
